// File: rtl/tinyriscv_pkg.sv
// Shared tinyriscv encodings plus the divide-controller state type.
package tinyriscv_pkg;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_ctrl_state_t;

endpackage

// File: rtl/div_result_cache.sv
// Single-entry memo of the last completed divide {op, operands, result}.
// Only instantiated when DIV_CTRL_RESULT_CACHE_EN is defined.
module div_result_cache
  import tinyriscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             upd_en,
  input  logic [2:0]       upd_op,
  input  logic [WIDTH-1:0] upd_dividend,
  input  logic [WIDTH-1:0] upd_divisor,
  input  logic [WIDTH-1:0] upd_result,
  input  logic [2:0]       lookup_op,
  input  logic [WIDTH-1:0] lookup_dividend,
  input  logic [WIDTH-1:0] lookup_divisor,
  output logic             hit,
  output logic [WIDTH-1:0] data
);

  logic             vld_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] result_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q      <= 1'b0;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
    end else if (upd_en) begin
      vld_q      <= 1'b1;
      op_q       <= upd_op;
      dividend_q <= upd_dividend;
      divisor_q  <= upd_divisor;
      result_q   <= upd_result;
    end
  end

  assign hit  = vld_q && (op_q == lookup_op) && (dividend_q == lookup_dividend)
                && (divisor_q == lookup_divisor);
  assign data = result_q;

endmodule

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider: latch, stall, writeback, flush abort.
// Optional last-result reuse enabled by defining DIV_CTRL_RESULT_CACHE_EN.
//
// state    | meaning
// DIV_IDLE | waiting for a divide-family request
// DIV_BUSY | divider running, pipeline held
// DIV_DONE | one-cycle writeback, divider valid low
module div_ctrl
  import tinyriscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             flush_i,
  output logic             hold_o,
  output logic             wb_valid_o,
  output logic [WIDTH-1:0] wb_data_o,
  output logic [4:0]       wb_addr_o,
  output logic             div_valid_o,
  output logic [2:0]       div_op_o,
  output logic [WIDTH-1:0] div_dividend_o,
  output logic [WIDTH-1:0] div_divisor_o,
  input  logic [WIDTH-1:0] div_data_i,
  input  logic             div_ready_i
);

  div_ctrl_state_t  state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] result_q;
  logic             accept;
  logic             hit;
  logic             capture;

  assign accept  = (state_q == DIV_IDLE) && req_i && op_i[2] && !flush_i;
  assign capture = (state_q == DIV_BUSY) && div_ready_i && !flush_i;

`ifdef DIV_CTRL_RESULT_CACHE_EN
  logic             cache_hit;
  logic [WIDTH-1:0] cache_data;

  div_result_cache #(.WIDTH(WIDTH)) u_cache (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .upd_en          ((state_q == DIV_DONE) && !flush_i),
    .upd_op          (op_q),
    .upd_dividend    (dividend_q),
    .upd_divisor     (divisor_q),
    .upd_result      (result_q),
    .lookup_op       (op_i),
    .lookup_dividend (dividend_i),
    .lookup_divisor  (divisor_i),
    .hit             (cache_hit),
    .data            (cache_data)
  );

  assign hit = accept && cache_hit;
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= DIV_IDLE;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rd_q       <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= op_i;
        dividend_q <= dividend_i;
        divisor_q  <= divisor_i;
        rd_q       <= rd_addr_i;
      end
      if (capture) begin
        result_q <= div_data_i;
      end
`ifdef DIV_CTRL_RESULT_CACHE_EN
      else if (hit) begin
        result_q <= cache_data;
      end
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_o     = 1'b0;
    wb_valid_o = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          state_d = hit ? DIV_DONE : DIV_BUSY;
          hold_o  = !hit;
        end
      end
      DIV_BUSY: begin
        hold_o = !flush_i;
        // flush wins over a simultaneous ready: the result is dropped
        if (flush_i)          state_d = DIV_IDLE;
        else if (div_ready_i) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        wb_valid_o = !flush_i;
        state_d    = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign div_valid_o    = (state_q == DIV_BUSY);
  assign div_op_o       = op_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign wb_data_o      = result_q;
  assign wb_addr_o      = rd_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural RISC-V divider beside it.
module tb_div_ctrl;
  import tinyriscv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 16;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_i = 1'b0;
  logic [2:0]   op_i = '0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic [4:0]   rd_addr_i = '0;
  logic         flush_i = 1'b0;
  logic         hold_o, wb_valid_o, div_valid_o;
  logic [W-1:0] wb_data_o, div_dividend_o, div_divisor_o;
  logic [4:0]   wb_addr_o;
  logic [2:0]   div_op_o;
  logic [W-1:0] div_data_i;
  logic         div_ready_i;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  div_ctrl #(.WIDTH(W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .op_i           (op_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .rd_addr_i      (rd_addr_i),
    .flush_i        (flush_i),
    .hold_o         (hold_o),
    .wb_valid_o     (wb_valid_o),
    .wb_data_o      (wb_data_o),
    .wb_addr_o      (wb_addr_o),
    .div_valid_o    (div_valid_o),
    .div_op_o       (div_op_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_data_i     (div_data_i),
    .div_ready_i    (div_ready_i)
  );

  function automatic logic [W-1:0] div_model(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      INST_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : W'($signed(a) / $signed(b));
      INST_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      INST_REM:  return (b == 0) ? a : ovf ? 32'h0 : W'($signed(a) % $signed(b));
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Divider stand-in: ready pulses once, LAT cycles into a valid-high run.
  int  dcnt;
  bit  ddone;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dcnt <= 0; ddone <= 1'b0; div_ready_i <= 1'b0; div_data_i <= '0;
    end else begin
      div_ready_i <= 1'b0;
      if (!div_valid_o) begin
        dcnt <= 0; ddone <= 1'b0;
      end else if (!ddone) begin
        if (dcnt == LAT) begin
          div_ready_i <= 1'b1;
          div_data_i  <= div_model(div_op_o, div_dividend_o, div_divisor_o);
          ddone       <= 1'b1;
        end else begin
          dcnt <= dcnt + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [W-1:0] exp, input string name);
    bit got = 0, hold_bad = 0, prev_rdy = 0;
    @(negedge clk_i);
    req_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    #1 chk({name, " hold_accept"}, W'(hold_o), 1);
    @(posedge clk_i);
    #1;
    req_i = 1'b0; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'h1234_5678; op_i = 3'b000;
    chk({name, " div_valid_rise"}, W'(div_valid_o), 1);
    chk({name, " opnd_latched"}, div_dividend_o, a);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_i);
      if (wb_valid_o) begin
        got = 1;
        chk({name, " wb_data"}, wb_data_o, exp);
        chk({name, " wb_addr"}, W'(wb_addr_o), W'(rd));
        chk({name, " div_valid_done"}, W'(div_valid_o), 0);
        chk({name, " hold_done"}, W'(hold_o), 0);
        chk({name, " wb_after_ready"}, W'(prev_rdy), 1);
      end else begin
        if (!hold_o) hold_bad = 1;
        prev_rdy = div_ready_i;
      end
    end
    chk({name, " wb_seen"}, W'(got), 1);
    chk({name, " hold_busy"}, W'(hold_bad), 0);
    @(negedge clk_i);
    chk({name, " wb_single"}, W'(wb_valid_o), 0);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   rd;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit seen;
    vecs[0] = '{INST_DIV,  32'd100,         32'd7,           5'd5, 32'd14,          "div_100_7"};
    vecs[1] = '{INST_REMU, 32'hFFFF_FFFF,   32'd16,          5'd9, 32'd15,          "remu_ff_16"};
    vecs[2] = '{INST_DIV,  32'h1234_5678,   32'd0,           5'd1, 32'hFFFF_FFFF,   "div_by_zero"};
    vecs[3] = '{INST_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   5'd2, 32'h8000_0000,   "div_ovf"};
    vecs[4] = '{INST_REM,  32'hFFFF_FF9C,   32'd7,           5'd4, 32'hFFFF_FFFE,   "rem_neg"};
    vecs[5] = '{INST_DIVU, 32'hFFFF_FFFF,   32'd2,           5'd0, 32'h7FFF_FFFF,   "divu_rd0"};
    vecs[6] = '{INST_REM,  32'd100,         32'd7,           5'd6, 32'd2,           "rem_100_7"};
    vecs[7] = '{INST_REMU, 32'd5,           32'd0,           5'd7, 32'd5,           "remu_by_zero"};

    #1;
    chk("rst hold", W'(hold_o), 0);
    chk("rst wb_valid", W'(wb_valid_o), 0);
    chk("rst div_valid", W'(div_valid_o), 0);
    chk("rst wb_data", wb_data_o, 0);
    chk("rst div_op", W'(div_op_o), 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].name);

    // non-divide funct3 and flush-with-request are both ignored in IDLE
    @(negedge clk_i);
    req_i = 1'b1; op_i = 3'b001; dividend_i = 32'd9; divisor_i = 32'd3;
    #1 chk("nondiv hold", W'(hold_o), 0);
    @(posedge clk_i); #1 chk("nondiv no_accept", W'(div_valid_o), 0);
    op_i = INST_DIV; flush_i = 1'b1;
    #1 chk("req_flush hold", W'(hold_o), 0);
    @(posedge clk_i); #1 chk("req_flush no_accept", W'(div_valid_o), 0);
    req_i = 1'b0; flush_i = 1'b0;

    // flush ten cycles into BUSY
    @(negedge clk_i);
    req_i = 1'b1; op_i = INST_DIVU; dividend_i = 32'd77; divisor_i = 32'd7; rd_addr_i = 5'd8;
    @(posedge clk_i); #1 req_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("flush pre div_valid", W'(div_valid_o), 1);
    flush_i = 1'b1;
    #1 chk("flush hold", W'(hold_o), 0);
    @(posedge clk_i); #1 flush_i = 1'b0;
    chk("flush div_valid_drop", W'(div_valid_o), 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (wb_valid_o || div_valid_o) seen = 1;
    end
    chk("flush no_wb", W'(seen), 0);
    run_op(INST_DIVU, 32'd50, 32'd5, 5'd3, 32'd10, "divu_after_flush");

    // asynchronous reset mid-BUSY
    @(negedge clk_i);
    req_i = 1'b1; op_i = INST_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd11;
    @(posedge clk_i); #1 req_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst hold", W'(hold_o), 0);
    chk("arst div_valid", W'(div_valid_o), 0);
    chk("arst wb_data", wb_data_o, 0);
    chk("arst wb_addr", W'(wb_addr_o), 0);
    chk("arst div_dividend", div_dividend_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (wb_valid_o || div_valid_o) seen = 1;
    end
    chk("arst no_wb", W'(seen), 0);

`ifdef DIV_CTRL_RESULT_CACHE_EN
    run_op(INST_DIV, 32'd100, 32'd7, 5'd5, 32'd14, "cache_fill");
    @(negedge clk_i);
    req_i = 1'b1; op_i = INST_DIV; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd12;
    #1 chk("hit hold", W'(hold_o), 0);
    @(posedge clk_i); #1 req_i = 1'b0;
    chk("hit div_valid", W'(div_valid_o), 0);
    @(negedge clk_i);
    chk("hit wb_valid", W'(wb_valid_o), 1);
    chk("hit wb_data", wb_data_o, 32'd14);
    chk("hit wb_addr", W'(wb_addr_o), 32'd12);
    chk("hit div_valid_done", W'(div_valid_o), 0);
    run_op(INST_REM, 32'd100, 32'd7, 5'd6, 32'd2, "cache_miss_rem");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
